// File: rtl/sdp_sram_pipe.sv
// Simple-dual-port SRAM with byte-masked writes, a READ_LATENCY-deep read pipe and hardware zero-fill after reset.
// Define SDP_SRAM_BYPASS_EN for write-first behaviour on same-edge same-address collisions (default: read-first).
module sdp_sram_pipe #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_init_addr;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic                    w_init_we;
    logic                    w_wr_in_range;
    logic                    w_rd_in_range;
    logic                    w_wr_fire;
    logic                    w_rd_fire;
    logic [DATA_WIDTH-1:0]   w_wr_mask;
    logic [DATA_WIDTH-1:0]   w_rd_word;
    logic                    r_pipe_valid [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   r_pipe_data  [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_INIT: if (r_init_addr == LAST_ADDR) w_state_next = S_RUN;
            S_RUN:  w_state_next = S_RUN;
        endcase
    end

    always_comb begin
        ready     = (r_state == S_RUN);
        w_init_we = (r_state == S_INIT);
    end

    // Counter parks on the last address once the fill completes; only reset rewinds it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_addr <= '0;
        end else if (w_init_we && (r_init_addr != LAST_ADDR)) begin
            r_init_addr <= r_init_addr + 1'b1;
        end
    end

    assign w_wr_in_range = (32'(wr_addr) < 32'(DEPTH));
    assign w_rd_in_range = (32'(rd_addr) < 32'(DEPTH));
    assign w_wr_fire     = ready & wr_en & ~rst & w_wr_in_range;
    assign w_rd_fire     = ready & rd_en & ~rst;

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_mask
            assign w_wr_mask[8*gi +: 8] = {8{wr_be[gi]}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_init_we && !rst) begin
            r_mem[r_init_addr[IDX_W-1:0]] <= '0;
        end else if (w_wr_fire) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_be[b]) begin
                    r_mem[wr_addr[IDX_W-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Out-of-range reads still flow down the pipe, carrying zero.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            w_rd_word = r_mem[rd_addr[IDX_W-1:0]];
        end
`ifdef SDP_SRAM_BYPASS_EN
        if (w_rd_in_range && w_wr_fire && (wr_addr == rd_addr)) begin
            w_rd_word = (w_rd_word & ~w_wr_mask) | (wr_data & w_wr_mask);
        end
`endif
    end

    // Each stage only captures data when a valid word arrives, so the last stage holds between strobes.
    generate
        for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_pipe_valid[gi] <= 1'b0;
                        r_pipe_data[gi]  <= '0;
                    end else begin
                        r_pipe_valid[gi] <= w_rd_fire;
                        if (w_rd_fire) begin
                            r_pipe_data[gi] <= w_rd_word;
                        end
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_pipe_valid[gi] <= 1'b0;
                        r_pipe_data[gi]  <= '0;
                    end else begin
                        r_pipe_valid[gi] <= r_pipe_valid[gi-1];
                        if (r_pipe_valid[gi-1]) begin
                            r_pipe_data[gi] <= r_pipe_data[gi-1];
                        end
                    end
                end
            end
        end
    endgenerate

    assign rd_valid = r_pipe_valid[READ_LATENCY-1];
    assign rd_data  = r_pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_sdp_sram_pipe.sv
// Bench for sdp_sram_pipe: four instances (latency 2/1/4, and DEPTH=1000) share one stimulus stream and are
// compared every cycle against a due-time scheduled reference model of the memory.
module tb_sdp_sram_pipe;
    localparam int N = 4;
    localparam int DEP [N] = '{1024, 1024, 1024, 1000};
    localparam int LAT [N] = '{2, 1, 4, 2};

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic        obs_ready [N];
    logic        obs_valid [N];
    logic [31:0] obs_data  [N];

    logic [31:0] mmem [N][1024];
    bit          rdy_m [N];
    int          fill_cnt [N];
    bit          sv [N][8];
    logic [31:0] sd [N][8];
    bit          ev [N];
    logic [31:0] ed [N];
    int          cyc;
    int          errors;
    int          checks;

    sdp_sram_pipe #(.READ_LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .ready(obs_ready[0]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(obs_valid[0]), .rd_data(obs_data[0]));
    sdp_sram_pipe #(.READ_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .ready(obs_ready[1]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(obs_valid[1]), .rd_data(obs_data[1]));
    sdp_sram_pipe #(.READ_LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .ready(obs_ready[2]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(obs_valid[2]), .rd_data(obs_data[2]));
    sdp_sram_pipe #(.DEPTH(1000), .READ_LATENCY(2)) u_d1000 (
        .clk(clk), .rst(rst), .ready(obs_ready[3]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(obs_valid[3]), .rd_data(obs_data[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;
    endtask

    task automatic set_wr(input logic [9:0] a, input logic [31:0] dat, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = dat; wr_be = be;
    endtask

    task automatic set_rd(input logic [9:0] a);
        rd_en = 1'b1; rd_addr = a;
    endtask

    // One clock edge; the model applies the behavioural rules for that edge, outputs are sampled 1ns later.
    task automatic step();
        logic [31:0] w;
        int slot;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < N; d++) begin
            if (rst) begin
                rdy_m[d] = 1'b0; fill_cnt[d] = 0; ev[d] = 1'b0; ed[d] = '0;
                for (int k = 0; k < 8; k++) sv[d][k] = 1'b0;
            end else begin
                if (!rdy_m[d]) begin
                    fill_cnt[d]++;
                    if (fill_cnt[d] == DEP[d]) begin
                        rdy_m[d] = 1'b1;
                        for (int a = 0; a < 1024; a++) mmem[d][a] = '0;
                    end
                end else begin
                    if (rd_en) begin
                        w = (int'(rd_addr) < DEP[d]) ? mmem[d][rd_addr] : 32'h0;
`ifdef SDP_SRAM_BYPASS_EN
                        if (wr_en && (wr_addr == rd_addr) && (int'(rd_addr) < DEP[d]))
                            for (int b = 0; b < 4; b++) if (wr_be[b]) w[8*b +: 8] = wr_data[8*b +: 8];
`endif
                        slot = (cyc + LAT[d] - 1) % 8;
                        sv[d][slot] = 1'b1;
                        sd[d][slot] = w;
                    end
                    if (wr_en && (int'(wr_addr) < DEP[d]))
                        for (int b = 0; b < 4; b++) if (wr_be[b]) mmem[d][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                end
                slot = cyc % 8;
                ev[d] = sv[d][slot];
                if (ev[d]) begin
                    ed[d] = sd[d][slot];
                    sv[d][slot] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int rdy_at [N];
        int pulses [N];
        int n;
        idle_inputs();
        rst = 1'b1;
        step();
        for (int d = 0; d < N; d++) begin
            checks++;
            if (obs_ready[d] !== 1'b0 || obs_valid[d] !== 1'b0 || obs_data[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state dut%0d got ready=%b valid=%b data=%h expected 0/0/00000000",
                         d, obs_ready[d], obs_valid[d], obs_data[d]);
            end
            rdy_at[d] = 0; pulses[d] = 0;
        end
        rst = 1'b0;
        n = 0;
        while (n < 1100 && (rdy_at[0] == 0 || rdy_at[1] == 0 || rdy_at[2] == 0 || rdy_at[3] == 0)) begin
            step();
            n++;
            for (int d = 0; d < N; d++) if (obs_ready[d] === 1'b1 && rdy_at[d] == 0) rdy_at[d] = n;
        end
        for (int d = 0; d < N; d++) begin
            checks++;
            if (rdy_at[d] != DEP[d]) begin
                errors++;
                $display("FAIL ready_rise dut%0d got edge=%0d expected edge=%0d", d, rdy_at[d], DEP[d]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            if (i == 0) set_rd(10'h005);
            if (i == 1) set_rd(10'h3FF);
            step();
            for (int d = 0; d < N; d++) begin
                checks++;
                if (obs_ready[d] !== rdy_m[d] || obs_valid[d] !== ev[d] || obs_data[d] !== ed[d]) begin
                    errors++;
                    $display("FAIL init_read dut%0d cyc=%0d got %b/%b/%h expected %b/%b/%h", d, cyc,
                             obs_ready[d], obs_valid[d], obs_data[d], rdy_m[d], ev[d], ed[d]);
                end
                if (obs_valid[d] === 1'b1) begin
                    pulses[d]++;
                    $display("rd dut%0d cyc=%0d data=%h", d, cyc, obs_data[d]);
                    checks++;
                    if (obs_data[d] !== 32'h0) begin
                        errors++;
                        $display("FAIL init_zero dut%0d got %h expected 00000000", d, obs_data[d]);
                    end
                end
            end
        end
        for (int d = 0; d < N; d++) begin
            checks++;
            if (pulses[d] != 2) begin
                errors++;
                $display("FAIL init_pulses dut%0d got %0d expected 2", d, pulses[d]);
            end
        end
    endtask

    task automatic test_byte_mask();
        int pulses [N];
        for (int d = 0; d < N; d++) pulses[d] = 0;
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            if (i == 0) set_wr(10'h010, 32'hAABBCCDD, 4'hF);
            if (i == 1) set_wr(10'h010, 32'h11223344, 4'b0101);
            if (i == 2) set_rd(10'h010);
            step();
            for (int d = 0; d < N; d++) begin
                checks++;
                if (obs_ready[d] !== rdy_m[d] || obs_valid[d] !== ev[d] || obs_data[d] !== ed[d]) begin
                    errors++;
                    $display("FAIL byte_mask dut%0d cyc=%0d got %b/%b/%h expected %b/%b/%h", d, cyc,
                             obs_ready[d], obs_valid[d], obs_data[d], rdy_m[d], ev[d], ed[d]);
                end
                if (obs_valid[d] === 1'b1) begin
                    pulses[d]++;
                    $display("rd dut%0d cyc=%0d data=%h", d, cyc, obs_data[d]);
                    checks++;
                    if (obs_data[d] !== 32'hAA22CC44) begin
                        errors++;
                        $display("FAIL byte_mask_value dut%0d got %h expected aa22cc44", d, obs_data[d]);
                    end
                end
            end
        end
        for (int d = 0; d < N; d++) begin
            checks++;
            if (pulses[d] != 1) begin
                errors++;
                $display("FAIL byte_mask_pulses dut%0d got %0d expected 1", d, pulses[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses [N];
        int first_v [N];
        int issue_cyc;
        issue_cyc = 0;
        for (int d = 0; d < N; d++) begin pulses[d] = 0; first_v[d] = 0; end
        for (int i = 0; i < 22; i++) begin
            idle_inputs();
            if (i < 8) set_wr(10'(i), $urandom, 4'hF);
            else if (i < 16) set_rd(10'(i - 8));
            step();
            if (i == 8) issue_cyc = cyc;
            for (int d = 0; d < N; d++) begin
                checks++;
                if (obs_ready[d] !== rdy_m[d] || obs_valid[d] !== ev[d] || obs_data[d] !== ed[d]) begin
                    errors++;
                    $display("FAIL back_to_back dut%0d cyc=%0d got %b/%b/%h expected %b/%b/%h", d, cyc,
                             obs_ready[d], obs_valid[d], obs_data[d], rdy_m[d], ev[d], ed[d]);
                end
                if (obs_valid[d] === 1'b1) begin
                    if (pulses[d] == 0) first_v[d] = cyc;
                    pulses[d]++;
                    $display("rd dut%0d cyc=%0d data=%h", d, cyc, obs_data[d]);
                end
            end
        end
        for (int d = 0; d < N; d++) begin
            checks++;
            if (pulses[d] != 8 || first_v[d] != issue_cyc + LAT[d] - 1) begin
                errors++;
                $display("FAIL b2b_timing dut%0d got pulses=%0d first=%0d expected pulses=8 first=%0d",
                         d, pulses[d], first_v[d], issue_cyc + LAT[d] - 1);
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] exp_coll;
`ifdef SDP_SRAM_BYPASS_EN
        exp_coll = 32'h0000BEEF;
`else
        exp_coll = 32'h00000000;
`endif
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            if (i == 0) set_wr(10'h020, 32'h0, 4'hF);
            if (i == 1) begin set_wr(10'h020, 32'hDEADBEEF, 4'b0011); set_rd(10'h020); end
            step();
            for (int d = 0; d < N; d++) begin
                checks++;
                if (obs_ready[d] !== rdy_m[d] || obs_valid[d] !== ev[d] || obs_data[d] !== ed[d]) begin
                    errors++;
                    $display("FAIL collision dut%0d cyc=%0d got %b/%b/%h expected %b/%b/%h", d, cyc,
                             obs_ready[d], obs_valid[d], obs_data[d], rdy_m[d], ev[d], ed[d]);
                end
                if (obs_valid[d] === 1'b1) begin
                    $display("rd dut%0d cyc=%0d data=%h", d, cyc, obs_data[d]);
                    checks++;
                    if (obs_data[d] !== exp_coll) begin
                        errors++;
                        $display("FAIL collision_value dut%0d got %h expected %h", d, obs_data[d], exp_coll);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        int pulses [N];
        int n;
        for (int d = 0; d < N; d++) pulses[d] = 0;
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            if (i == 0) set_wr(10'h030, 32'hCAFEF00D, 4'hF);
            if (i >= 1 && i <= 3) set_rd(10'(10'h02F + i));
            if (i == 4) rst = 1'b1;
            step();
            for (int d = 0; d < N; d++) begin
                checks++;
                if (obs_ready[d] !== rdy_m[d] || obs_valid[d] !== ev[d] || obs_data[d] !== ed[d]) begin
                    errors++;
                    $display("FAIL midstream dut%0d cyc=%0d got %b/%b/%h expected %b/%b/%h", d, cyc,
                             obs_ready[d], obs_valid[d], obs_data[d], rdy_m[d], ev[d], ed[d]);
                end
            end
        end
        for (int d = 0; d < N; d++) begin
            checks++;
            if (obs_ready[d] !== 1'b0 || obs_valid[d] !== 1'b0 || obs_data[d] !== 32'h0) begin
                errors++;
                $display("FAIL midstream_reset dut%0d got %b/%b/%h expected 0/0/00000000",
                         d, obs_ready[d], obs_valid[d], obs_data[d]);
            end
        end
        rst = 1'b0;
        n = 0;
        while (n < 1100 && !(obs_ready[0] === 1'b1 && obs_ready[1] === 1'b1 &&
                             obs_ready[2] === 1'b1 && obs_ready[3] === 1'b1)) begin
            if (n == 5) set_rd(10'h030);
            else idle_inputs();
            step();
            n++;
            for (int d = 0; d < N; d++) if (obs_valid[d] === 1'b1) pulses[d]++;
        end
        checks++;
        if (n >= 1100) begin
            errors++;
            $display("FAIL refill_timeout got %0d edges expected ready within 1100", n);
        end
        for (int d = 0; d < N; d++) begin
            checks++;
            if (pulses[d] != 0) begin
                errors++;
                $display("FAIL midstream_pulses dut%0d got %0d expected 0", d, pulses[d]);
            end
        end
        for (int i = 0; i < 7; i++) begin
            idle_inputs();
            if (i == 0) set_rd(10'h030);
            step();
            for (int d = 0; d < N; d++) begin
                checks++;
                if (obs_ready[d] !== rdy_m[d] || obs_valid[d] !== ev[d] || obs_data[d] !== ed[d]) begin
                    errors++;
                    $display("FAIL refill_read dut%0d cyc=%0d got %b/%b/%h expected %b/%b/%h", d, cyc,
                             obs_ready[d], obs_valid[d], obs_data[d], rdy_m[d], ev[d], ed[d]);
                end
                if (obs_valid[d] === 1'b1) begin
                    $display("rd dut%0d cyc=%0d data=%h", d, cyc, obs_data[d]);
                    checks++;
                    if (obs_data[d] !== 32'h0) begin
                        errors++;
                        $display("FAIL refill_zero dut%0d got %h expected 00000000", d, obs_data[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        int d3_hits;
        d3_hits = 0;
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            if (i == 0) set_wr(10'h000, 32'h5A5A1234, 4'hF);
            if (i == 1) set_wr(10'h3E8, 32'h12345678, 4'hF);
            if (i == 2) set_rd(10'h3E8);
            if (i == 3) set_rd(10'h000);
            step();
            for (int d = 0; d < N; d++) begin
                checks++;
                if (obs_ready[d] !== rdy_m[d] || obs_valid[d] !== ev[d] || obs_data[d] !== ed[d]) begin
                    errors++;
                    $display("FAIL out_of_range dut%0d cyc=%0d got %b/%b/%h expected %b/%b/%h", d, cyc,
                             obs_ready[d], obs_valid[d], obs_data[d], rdy_m[d], ev[d], ed[d]);
                end
                if (obs_valid[d] === 1'b1) $display("rd dut%0d cyc=%0d data=%h", d, cyc, obs_data[d]);
            end
            if (obs_valid[3] === 1'b1) begin
                d3_hits++;
                checks++;
                if (obs_data[3] !== ((d3_hits == 1) ? 32'h0 : 32'h5A5A1234)) begin
                    errors++;
                    $display("FAIL oor_value read%0d got %h expected %h", d3_hits, obs_data[3],
                             (d3_hits == 1) ? 32'h0 : 32'h5A5A1234);
                end
            end
        end
        checks++;
        if (d3_hits != 2) begin
            errors++;
            $display("FAIL oor_pulses got %0d expected 2", d3_hits);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 406; i++) begin
            idle_inputs();
            if (i < 400) begin
                if ($urandom_range(0, 9) < 6)
                    set_wr($urandom_range(0, 1) ? 10'($urandom_range(0, 15)) : 10'(10'h3E0 + $urandom_range(0, 31)),
                           $urandom, 4'($urandom_range(0, 15)));
                if ($urandom_range(0, 9) < 6)
                    set_rd($urandom_range(0, 1) ? 10'($urandom_range(0, 15)) : 10'(10'h3E0 + $urandom_range(0, 31)));
                if ($urandom_range(0, 3) == 0 && rd_en) wr_addr = rd_addr;
            end
            step();
            for (int d = 0; d < N; d++) begin
                checks++;
                if (obs_ready[d] !== rdy_m[d] || obs_valid[d] !== ev[d] || obs_data[d] !== ed[d]) begin
                    errors++;
                    $display("FAIL random dut%0d cyc=%0d got %b/%b/%h expected %b/%b/%h", d, cyc,
                             obs_ready[d], obs_valid[d], obs_data[d], rdy_m[d], ev[d], ed[d]);
                end
                if (obs_valid[d] === 1'b1) $display("rd dut%0d cyc=%0d data=%h", d, cyc, obs_data[d]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_byte_mask();
        test_back_to_back();
        test_collision();
        test_reset_midstream();
        test_out_of_range();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
